// File: rtl/regfile_alu_core.sv
// 32x32 register file with two combinational read ports, plus the ALU control decoder and a combinational ALU.
// Optional same-cycle write-through on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_alu_core (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_con,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [31:0] alu_result,
    output logic        alu_zero
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    // Register 0 is reset to zero and never written, so it stays zero.
    assign wr_en = reg_write && (write_reg != 5'd0) && reset_n;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        read_data1 = regs_q[read_reg1];
        read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (write_reg == read_reg1)) read_data1 = write_data;
        if (wr_en && (write_reg == read_reg2)) read_data2 = write_data;
`endif
        if (!reset_n || (read_reg1 == 5'd0)) read_data1 = '0;
        if (!reset_n || (read_reg2 == 5'd0)) read_data2 = '0;
    end

    always_comb begin
        alu_con = ALU_ADD;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100010, 6'b100011: alu_con = ALU_SUB;
                6'b100100:            alu_con = ALU_AND;
                6'b100101:            alu_con = ALU_OR;
                6'b100111:            alu_con = ALU_NOR;
                6'b101010:            alu_con = ALU_SLT;
                default:              alu_con = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                6'b000100, 6'b000101: alu_con = ALU_SUB;
                6'b001100:            alu_con = ALU_AND;
                6'b001101:            alu_con = ALU_OR;
                6'b001010:            alu_con = ALU_SLT;
                default:              alu_con = ALU_ADD;
            endcase
        end
    end

    // Unused encodings (011, 101) fall through to zero.
    always_comb begin
        alu_result = '0;
        case (alu_con)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            ALU_NOR: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);

endmodule

// File: tb/tb_regfile_alu_core.sv
// Randomized self-checking bench for regfile_alu_core against a behavioural model.
// Define REGFILE_BYPASS_EN here as well as in the RTL to check the write-through build.
`timescale 1ns/1ps
module tb_regfile_alu_core;

    logic        clock;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [2:0]  alu_con;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];

    regfile_alu_core dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .opcode     (opcode),
        .funct      (funct),
        .alu_con    (alu_con),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: operation mnemonic 0=AND 1=OR 2=ADD 3=SUB 4=SLT 5=NOR.
    function automatic int op_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'h20 || fn == 6'h21) return 2;
            if (fn == 6'h22 || fn == 6'h23) return 3;
            if (fn == 6'h24) return 0;
            if (fn == 6'h25) return 1;
            if (fn == 6'h27) return 5;
            if (fn == 6'h2a) return 4;
            return 2;
        end
        if (op == 6'h04 || op == 6'h05) return 3;
        if (op == 6'h0c) return 0;
        if (op == 6'h0d) return 1;
        if (op == 6'h0a) return 4;
        return 2;
    endfunction

    function automatic logic [2:0] enc_of(input int m);
        logic [2:0] tab [6];
        tab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100};
        return tab[m];
    endfunction

    function automatic logic [31:0] alu_of(input int m, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (m)
            0: return a & b;
            1: return a | b;
            2: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            3: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4: return (sa < sb) ? 32'd1 : 32'd0;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (!reset_n || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_reg == idx) return write_data;
`endif
        return model[idx];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'd0;
        end else if (reg_write && write_reg != 5'd0) begin
            model[write_reg] <= write_data;
        end
    end

    // Every cycle, halfway between rising edges, compare all outputs to the model.
    always @(negedge clock) begin
        logic [31:0] r;
        int m;
        m = op_of(opcode, funct);
        r = alu_of(m, alu_a, alu_b);
        check("rd1", read_data1, m_read(read_reg1));
        check("rd2", read_data2, m_read(read_reg2));
        check("alu_con", {29'd0, alu_con}, {29'd0, enc_of(m)});
        check("alu_result", alu_result, r);
        check("alu_zero", {31'd0, alu_zero}, {31'd0, (r == 32'd0)});
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        opcode = op; funct = fn; alu_a = a; alu_b = b;
        #1;
    endtask

    logic [5:0]  op_tab [12];
    logic [5:0]  fn_tab [9];
    logic [31:0] val_tab [6];

    initial begin
        op_tab  = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
        fn_tab  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00};
        val_tab = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0};

        reset_n = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
        read_reg1 = 5'd5; read_reg2 = 5'd0;
        opcode = 6'd0; funct = 6'h20; alu_a = 32'd0; alu_b = 32'd0;
        #2;
        check("reset_rd1", read_data1, 32'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;

        // Write path and register 0.
        next_cycle();
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
        next_cycle();
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h00001234;
        #1;
        check("wr_reg5", read_data1, 32'hDEADBEEF);
        next_cycle();
        reg_write = 1'b0; read_reg1 = 5'd0;
        #1;
        check("wr_reg0", read_data1, 32'd0);

        // Decode.
        set_op(6'h00, 6'h22, 32'd0, 32'd0); check("dec_sub",  {29'd0, alu_con}, 32'd6);
        set_op(6'h0d, 6'h00, 32'd0, 32'd0); check("dec_ori",  {29'd0, alu_con}, 32'd1);
        set_op(6'h04, 6'h00, 32'd0, 32'd0); check("dec_beq",  {29'd0, alu_con}, 32'd6);
        set_op(6'h3f, 6'h00, 32'd0, 32'd0); check("dec_dflt", {29'd0, alu_con}, 32'd2);

        // Arithmetic corner cases.
        set_op(6'h00, 6'h20, 32'hFFFFFFFF, 32'd1);
        check("add_wrap", alu_result, 32'd0);
        check("add_zero", {31'd0, alu_zero}, 32'd1);
        set_op(6'h00, 6'h22, 32'd5, 32'd7);          check("sub_neg", alu_result, 32'hFFFFFFFE);
        set_op(6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1);   check("slt_sgn", alu_result, 32'd1);
        set_op(6'h00, 6'h27, 32'd0, 32'd0);          check("nor_00",  alu_result, 32'hFFFFFFFF);

        // Write-through on read port 2.
        next_cycle();
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h11111111;
        next_cycle();
        write_data = 32'hA5A5A5A5; read_reg2 = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass", read_data2, 32'hA5A5A5A5);
`else
        check("bypass", read_data2, 32'h11111111);
`endif
        next_cycle();
        reg_write = 1'b0;
        #1;
        check("after_edge", read_data2, 32'hA5A5A5A5);

        // Fill regs 1..31, then an async reset pulse mid-cycle.
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            reg_write = 1'b1; write_reg = 5'(i); write_data = 32'h100 + 32'(i);
        end
        next_cycle();
        reg_write = 1'b0; read_reg1 = 5'd17;
        #1;
        check("pre_reset", read_data1, 32'h111);
        next_cycle();
        reset_n = 1'b0;
        for (int i = 1; i < 32; i++) begin
            read_reg1 = 5'(i);
            #0.1;
            if (i == 31) check("async_clr", read_data1, 32'd0);
            else if (read_data1 !== 32'd0) check("async_clr", read_data1, 32'd0);
        end
        #0.5;
        reset_n = 1'b1;
        next_cycle();
        reset_n = 1'b1;
        #1;
        read_reg2 = 5'd31;
        #0.1;
        check("post_reset", read_data2, 32'd0);

        // Randomized traffic, compared every cycle by the negedge process.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            reg_write  = ($urandom_range(0, 2) != 0);
            write_reg  = 5'($urandom_range(0, 31));
            write_data = ($urandom_range(0, 3) == 0) ? val_tab[$urandom_range(0, 5)] : $urandom;
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            opcode     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 11)];
            funct      = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 8)];
            alu_a      = ($urandom_range(0, 2) == 0) ? val_tab[$urandom_range(0, 5)] : $urandom;
            alu_b      = ($urandom_range(0, 3) == 0) ? alu_a : (($urandom_range(0, 2) == 0) ? val_tab[$urandom_range(0, 5)] : $urandom);
            if (n % 500 == 250) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_alu_core.md
REGFILE_ALU_CORE -- requirements
Module: regfile_alu_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports in this order:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-002 reg_write  in  1  register-file write enable, sampled at the rising edge of clock.
REQ-003 write_reg  in  5  destination register index.
REQ-004 write_data  in  32  data to write.
REQ-005 read_reg1 / read_reg2  in  5 each  read-port indices.
REQ-006 read_data1 / read_data2  out  32 each  combinational read data.
REQ-007 opcode  in  6  instruction bits [31:26].
REQ-008 funct  in  6  instruction bits [5:0].
REQ-009 alu_con  out  3  decoded ALU operation.
REQ-010 alu_a / alu_b  in  32 each  ALU operands, supplied externally after forwarding muxes.
REQ-011 alu_result  out  32  ALU result.
REQ-012 alu_zero  out  1  high when alu_result equals 0.

Function
REQ-013 The register file SHALL hold 32 x 32-bit registers.
REQ-014 Register 0 SHALL always read 0, and writes to register 0 SHALL be ignored.
REQ-015 A write SHALL occur at the rising edge of clock when reg_write=1 and write_reg!=0.
REQ-016 Both read ports SHALL be combinational and independent; the two ports reading the same index SHALL both return that register.
REQ-017 ALU control SHALL be purely combinational; alu_con encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR.
REQ-018 For opcode 000000, alu_con SHALL be decoded from funct:
- 100000/100001 ADD
- 100010/100011 SUB
- 100100 AND
- 100101 OR
- 100111 NOR
- 101010 SLT
- any other funct ADD
REQ-019 For other opcodes, alu_con SHALL be:
- 100011 lw, 101011 sw, 001000 addi: ADD
- 000100 beq, 000101 bne: SUB
- 001100 andi: AND
- 001101 ori: OR
- 001010 slti: SLT
- any other opcode: ADD
REQ-020 The ALU SHALL be combinational, with no registers between the alu_a/alu_b/alu_con inputs and alu_result.
REQ-021 ADD and SUB SHALL wrap modulo 2^32 with no overflow flag and no trap.
REQ-022 SLT SHALL perform a signed two's-complement compare and return 32'h00000001 or 32'h00000000.
REQ-023 NOR SHALL return ~(alu_a | alu_b).
REQ-024 alu_con values 011 and 101 SHALL produce alu_result 0.
REQ-025 alu_zero SHALL be derived combinationally from alu_result in every mode.

Reset
REQ-026 reset_n=0 SHALL immediately clear all 32 registers to 0, independent of clock.
REQ-027 While reset_n=0, writes SHALL be blocked and read_data1/read_data2 SHALL read 0.
REQ-028 The ALU and ALU control SHALL have no state; their outputs SHALL track their inputs during reset.
REQ-029 Write enable SHALL be honoured at the first rising edge of clock after reset_n deasserts.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN:
- When defined: if reg_write=1, write_reg!=0 and write_reg equals a read index, that port SHALL return write_data combinationally in the same cycle (write-through).
- When undefined: that port SHALL return the old value until after the clock edge.
- In both cases, register 0 SHALL never be bypassed.

Verification
REQ-031 Write path: reset, then write 32'hDEADBEEF to reg 5; read_reg1=5 -> read_data1=32'hDEADBEEF on the next cycle; write 32'h1234 to reg 0 -> reg 0 reads 0.
REQ-032 Async reset: write regs 1..31, pulse reset_n low mid-cycle -> all registers read 0 before the next clock edge.
REQ-033 Decode: opcode=000000 with funct=100010 -> alu_con=110; opcode=001101 -> 001; opcode=000100 -> 110; opcode=111111 -> 010.
REQ-034 Arithmetic:
- ADD 32'hFFFFFFFF + 1 -> alu_result 0, alu_zero=1.
- SUB 5-7 -> 32'hFFFFFFFE.
- SLT 32'hFFFFFFFF vs 1 -> 1.
- NOR 0,0 -> 32'hFFFFFFFF.
REQ-035 Bypass: same-cycle write of 32'hA5A5A5A5 to reg 9 with read_reg2=9 -> read_data2=32'hA5A5A5A5 before the edge with REGFILE_BYPASS_EN defined, old value without it.
